lal_count_sequencer: RTL and testbench
======================================

Name: lal_count_sequencer

Overview:
Sequential controller for the loadable down-counter / magnitude-compare datapath.
- Loads a start value, then decrements it one step per cycle, but only on cycles where the compare gate (cmp_a >= cmp_b) holds.
- Supports pause and abort, and reports completion.
- Sits between the control inputs (start/hold/abort) and the counter datapath, and owns all sequencing of that datapath.

Parameters:
CNT_W, 9, width of the down-counter and load value
CMP_W, 4, width of each compare operand

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  reset, asynchronous assert, active-low
start  in  1  request a new count run; sampled in IDLE only
load_value  in  CNT_W  start value, captured in the cycle start is accepted
hold  in  1  pause the count while high
abort  in  1  cancel the run, return to IDLE
cmp_a  in  CMP_W  compare operand A, unsigned
cmp_b  in  CMP_W  compare operand B, unsigned
count  out  CNT_W  current counter value
busy  out  1  high in LOAD, RUN and PAUSE
done  out  1  one-cycle pulse, high only in DONE
gate  out  1  combinational: cmp_a >= cmp_b
aborted  out  1  sticky: set when a run is aborted, cleared on the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, count=0, busy=0, done=0, aborted=0, load register=0. gate stays combinational.
- State encoding (3 bits): IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4. Codes 5-7 are illegal and go to IDLE on the next clock.
- busy and done decode from the registered state only; no combinational path from inputs.
- IDLE:
  - start=1 -> LOAD; capture load_value; clear aborted.
  - abort in IDLE is ignored.
- LOAD:
  - abort=1 -> IDLE, aborted=1, count unchanged.
  - Otherwise count <= captured value -> RUN.
- RUN, evaluated in this priority order:
  - abort -> IDLE, aborted=1.
  - hold -> PAUSE, count frozen.
  - count==0 -> DONE.
  - gate=1 -> count <= count-1.
  - gate=0 -> count unchanged, stay in RUN.
- PAUSE:
  - abort -> IDLE, aborted=1.
  - hold=0 -> RUN.
  - Otherwise stay in PAUSE. count never changes in PAUSE.
- DONE: done=1 for exactly one cycle, then IDLE. count stays 0 until the next LOAD.
- Latency: start sampled at edge E0; LOAD during cycle 1; with gate=1 and no hold, done is high in cycle N+3 for load_value=N.
  - N=0: LOAD, RUN(count==0), DONE, so done is high in cycle 3.
- Arithmetic: unsigned. The decrement is never applied at 0, so the counter never wraps. Maximum load 2^CNT_W-1 is supported.
- Simultaneous events:
  - abort beats hold beats terminal-count beats decrement.
  - start while busy is ignored; it is not queued.
  - start sampled in DONE is ignored; it must be presented again in IDLE.
- Reset mid-run returns to IDLE immediately and asynchronously. No done pulse is generated.

Decomposition:
- Package lal_seq_pkg holds:
  - the state enum type (IDLE/LOAD/RUN/PAUSE/DONE, 3-bit);
  - default CNT_W and CMP_W localparams;
  - a function for the terminal-count check.
- One sub-module, lal_mag_cmp (parameter CMP_W), computes gate = (a >= b) combinationally. It is instantiated once.
- The counter register and FSM live in the top level.

Test Plan:
- Reset: drive rst_n=0 mid-RUN with count=37 -> in the same cycle state=IDLE, count=0, busy=0, done=0, aborted=0. No done pulse after release.
- Basic run: load_value=5, cmp_a=9, cmp_b=3, start for 1 cycle -> busy high cycles 1-7, count goes 5,4,3,2,1,0, done high only in cycle 8.
- Gate stall: load_value=3, cmp_a=2, cmp_b=7 for 4 RUN cycles, then cmp_a=7 -> count holds 3 while gate=0, then decrements; done arrives 4 cycles later than the ungated run.
- Hold and abort: hold=1 at count=4 for 3 cycles -> PAUSE, count stays 4, then resumes. Next run: hold=1 and abort=1 together -> IDLE, aborted=1, no done.
- Boundaries: load_value=0 -> done in cycle 3. load_value=511 with gate=1 -> done in cycle 514, no wrap below 0.
- Ignored start: start pulsed repeatedly while busy and in DONE -> no restart, count sequence unchanged. Next start in IDLE clears aborted.

Source files
------------

// File: rtl/lal_seq_pkg.sv
// Shared types and helpers for the loadable down-counter sequencer.
// Holds the state encoding, default widths and the terminal-count check.
package lal_seq_pkg;

    localparam int unsigned CNT_W_DEF = 9;
    localparam int unsigned CMP_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Callers zero-extend the counter to 32 bits.
    function automatic logic is_terminal(input logic [31:0] value);
        return (value == '0);
    endfunction

endpackage

// File: rtl/lal_mag_cmp.sv
// Unsigned magnitude comparator: o_ge = (i_a >= i_b), purely combinational.
module lal_mag_cmp #(
    parameter int unsigned CMP_W = 4
) (
    input  logic [CMP_W-1:0] i_a,
    input  logic [CMP_W-1:0] i_b,
    output logic             o_ge
);

    assign o_ge = (i_a >= i_b);

endmodule

// File: rtl/lal_count_sequencer.sv
// Sequencer for the loadable down-counter: loads a start value and decrements
// it on gated cycles, with pause, abort and a one-cycle completion pulse.
module lal_count_sequencer
    import lal_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned CMP_W = CMP_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] load_value,
    input  logic             hold,
    input  logic             abort,
    input  logic [CMP_W-1:0] cmp_a,
    input  logic [CMP_W-1:0] cmp_b,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             gate,
    output logic             aborted
);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_load;
    logic             r_aborted;

    logic             w_gate;
    logic             w_capture;
    logic             w_load_cnt;
    logic             w_dec;
    logic             w_set_abort;
    logic             w_terminal;

    lal_mag_cmp #(
        .CMP_W (CMP_W)
    ) u_mag_cmp (
        .i_a  (cmp_a),
        .i_b  (cmp_b),
        .o_ge (w_gate)
    );

    assign w_terminal = is_terminal(32'(r_count));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority inside RUN: abort, hold, terminal count, then gated decrement.
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_load_cnt  = 1'b0;
        w_dec       = 1'b0;
        w_set_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next    = ST_LOAD;
                    w_capture = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next      = ST_IDLE;
                    w_set_abort = 1'b1;
                end else begin
                    w_next     = ST_RUN;
                    w_load_cnt = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next      = ST_IDLE;
                    w_set_abort = 1'b1;
                end else if (hold) begin
                    w_next = ST_PAUSE;
                end else if (w_terminal) begin
                    w_next = ST_DONE;
                end else if (w_gate) begin
                    w_dec = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    w_next      = ST_IDLE;
                    w_set_abort = 1'b1;
                end else if (!hold) begin
                    w_next = ST_RUN;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load <= '0;
        end else if (w_capture) begin
            r_load <= load_value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_load_cnt) begin
            r_count <= r_load;
        end else if (w_dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aborted <= 1'b0;
        end else if (w_capture) begin
            r_aborted <= 1'b0;
        end else if (w_set_abort) begin
            r_aborted <= 1'b1;
        end
    end

    assign count   = r_count;
    assign busy    = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done    = (r_state == ST_DONE);
    assign gate    = w_gate;
    assign aborted = r_aborted;

endmodule

// File: tb/tb_lal_count_sequencer.sv
// Directed and randomized bench for lal_count_sequencer against a
// cycle-level behavioural model of the counting rules.
module tb_lal_count_sequencer;

    localparam int unsigned CNT_W = 9;
    localparam int unsigned CMP_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] load_value;
    logic             hold;
    logic             abort;
    logic [CMP_W-1:0] cmp_a;
    logic [CMP_W-1:0] cmp_b;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             gate;
    logic             aborted;

    int errors = 0;
    int checks = 0;

    // Model: one flag per activity plus the count value.
    bit m_loading, m_running, m_paused, m_finishing, m_aborted;
    int m_cnt, m_captured;

    always #5 clk = ~clk;

    lal_count_sequencer #(
        .CNT_W (CNT_W),
        .CMP_W (CMP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .load_value (load_value),
        .hold       (hold),
        .abort      (abort),
        .cmp_a      (cmp_a),
        .cmp_b      (cmp_b),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .gate       (gate),
        .aborted    (aborted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_running = 0; m_paused = 0; m_finishing = 0;
        m_aborted = 0; m_cnt = 0; m_captured = 0;
    endtask

    task automatic model_step();
        bit idle;
        bit g;
        idle = !(m_loading || m_running || m_paused || m_finishing);
        g = (int'(cmp_a) >= int'(cmp_b));
        if (m_finishing) begin
            m_finishing = 0;
        end else if (idle) begin
            if (start) begin
                m_loading = 1; m_captured = int'(load_value); m_aborted = 0;
            end
        end else if (abort) begin
            m_loading = 0; m_running = 0; m_paused = 0; m_aborted = 1;
        end else if (m_loading) begin
            m_loading = 0; m_running = 1; m_cnt = m_captured;
        end else if (m_paused) begin
            if (!hold) begin m_paused = 0; m_running = 1; end
        end else begin
            if (hold) begin
                m_running = 0; m_paused = 1;
            end else if (m_cnt == 0) begin
                m_running = 0; m_finishing = 1;
            end else if (g) begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("count", 32'(count), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(m_loading || m_running || m_paused));
        chk("done", 32'(done), 32'(m_finishing));
        chk("aborted", 32'(aborted), 32'(m_aborted));
        chk("gate", 32'(gate), 32'(int'(cmp_a) >= int'(cmp_b)));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    // Presents start for one edge (E0); on return the bench is in cycle 1.
    task automatic launch(input int n);
        load_value = CNT_W'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Steps from the current cycle until done is seen; returns that cycle number.
    task automatic run_to_done(input int cur, input int limit, output int done_cyc);
        int c;
        c = cur;
        while (done !== 1'b1 && c < limit) begin
            step();
            c++;
        end
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout observed=no-done expected=done by cycle %0d", limit);
        end
        done_cyc = c;
    endtask

    initial begin
        int dc;
        rst_n = 1'b0; start = 1'b0; load_value = '0; hold = 1'b0; abort = 1'b0;
        cmp_a = 4'd9; cmp_b = 4'd3;
        model_reset();
        #1;
        check_outputs();
        #20;
        rst_n = 1'b1;
        step();

        // Basic run: N=5, done expected in cycle N+3.
        launch(5);
        chk("basic_busy_c1", 32'(busy), 32'd1);
        run_to_done(1, 40, dc);
        chk("basic_done_cycle", 32'(dc), 32'd8);
        chk("basic_count_end", 32'(count), 32'd0);
        step();
        chk("basic_idle", 32'(busy), 32'd0);

        // Async reset mid-run at count=37.
        launch(40);
        repeat (4) step();
        chk("pre_reset_count", 32'(count), 32'd37);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        step();
        #2;
        rst_n = 1'b1;
        repeat (4) step();

        // Gate stall: four gated-off RUN edges delay done by four cycles.
        cmp_a = 4'd2; cmp_b = 4'd7;
        launch(3);
        step();
        repeat (4) step();
        chk("stall_count_held", 32'(count), 32'd3);
        cmp_a = 4'd7;
        run_to_done(6, 40, dc);
        chk("stall_done_cycle", 32'(dc), 32'd3 + 32'd3 + 32'd4);
        step();

        // Hold at count=4 for three cycles.
        cmp_a = 4'd9; cmp_b = 4'd3;
        launch(6);
        repeat (3) step();
        chk("hold_pre_count", 32'(count), 32'd4);
        hold = 1'b1;
        repeat (3) step();
        chk("hold_frozen", 32'(count), 32'd4);
        chk("hold_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        run_to_done(7, 40, dc);
        chk("hold_done_cycle", 32'(dc), 32'd6 + 32'd3 + 32'd4);
        step();

        // Hold and abort together: abort wins.
        launch(10);
        repeat (3) step();
        hold = 1'b1; abort = 1'b1;
        step();
        hold = 1'b0; abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sticky", 32'(aborted), 32'd1);
        repeat (12) step();

        // Start repeated while busy and during DONE is ignored; accepted start clears aborted.
        launch(4);
        chk("restart_clears_aborted", 32'(aborted), 32'd0);
        start = 1'b1;
        run_to_done(1, 40, dc);
        chk("ignored_start_done_cycle", 32'(dc), 32'd7);
        step();
        start = 1'b0;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        step();

        // Boundaries: zero and maximum load.
        launch(0);
        run_to_done(1, 20, dc);
        chk("zero_done_cycle", 32'(dc), 32'd3);
        step();
        launch(511);
        step();
        chk("max_count_loaded", 32'(count), 32'd511);
        run_to_done(2, 600, dc);
        chk("max_done_cycle", 32'(dc), 32'd514);
        step();
        chk("max_no_wrap", 32'(count), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            start      = ($urandom_range(0, 5) == 0);
            hold       = ($urandom_range(0, 9) == 0);
            abort      = ($urandom_range(0, 39) == 0);
            cmp_a      = CMP_W'($urandom_range(0, 15));
            cmp_b      = CMP_W'($urandom_range(0, 15));
            load_value = CNT_W'($urandom_range(0, 12));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
